// File: rtl/csr_timer.sv
// CSR-mapped 16-bit timer with prescaler, compare match and level interrupt.
// Optional input-capture channel is built only when TIMER_CAPTURE_EN is defined.
module csr_timer #(
    parameter logic [15:0] PRESCALE_RST = 16'h0000,
    parameter logic [15:0] COMPARE_RST  = 16'hFFFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
`ifdef TIMER_CAPTURE_EN
    input  logic        cap_in,
`endif
    input  logic [15:0] csr_a,
    input  logic        csr_we,
    input  logic [15:0] csr_di,
    output logic [15:0] csr_do,
    output logic        irq
);

    localparam logic [2:0] AddrCtrl     = 3'd0;
    localparam logic [2:0] AddrStatus   = 3'd1;
    localparam logic [2:0] AddrCount    = 3'd2;
    localparam logic [2:0] AddrCompare  = 3'd3;
    localparam logic [2:0] AddrPrescale = 3'd4;
    localparam logic [2:0] AddrCapture  = 3'd5;

    logic [2:0]  addr;
    logic        unused_addr;
    logic        wr_ctrl, wr_status, wr_count, wr_compare, wr_prescale;

    logic [2:0]  ctrl_q, ctrl_d;
    logic        match_q, match_d;
    logic [15:0] count_q, count_d;
    logic [15:0] compare_q, compare_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] csr_do_q, rdata;
    logic        tick, hit, en_rise;

    assign addr        = csr_a[2:0];
    assign unused_addr = ^csr_a[15:3];

    assign wr_ctrl     = csr_we & (addr == AddrCtrl);
    assign wr_status   = csr_we & (addr == AddrStatus);
    assign wr_count    = csr_we & (addr == AddrCount);
    assign wr_compare  = csr_we & (addr == AddrCompare);
    assign wr_prescale = csr_we & (addr == AddrPrescale);

    assign tick    = ctrl_q[0] & (presc_q == prescale_q);
    assign hit     = tick & (count_q == compare_q);
    assign en_rise = wr_ctrl & csr_di[0] & ~ctrl_q[0];

    always_comb begin
        ctrl_d = ctrl_q;
        if (hit && !ctrl_q[1]) begin
            ctrl_d[0] = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = csr_di[2:0];
        end

        // Bus writes to COUNT override whatever the tick would have done.
        count_d = count_q;
        if (hit) begin
            if (ctrl_q[1]) begin
                count_d = 16'h0000;
            end
        end else if (tick) begin
            count_d = count_q + 16'd1;
        end
        if (wr_count) begin
            count_d = csr_di;
        end

        match_d = match_q;
        if (wr_status && csr_di[0]) begin
            match_d = 1'b0;
        end
        if (hit) begin
            match_d = 1'b1;
        end

        compare_d  = wr_compare ? csr_di : compare_q;
        prescale_d = wr_prescale ? csr_di : prescale_q;

        if (!ctrl_d[0] || wr_prescale || en_rise || tick) begin
            presc_d = 16'h0000;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [1:0]  cap_sync_q;
    logic        cap_prev_q;
    logic        cap_rise;
    logic [15:0] capture_q, capture_d;
    logic        capf_q, capf_d;

    assign cap_rise = cap_sync_q[1] & ~cap_prev_q;

    always_comb begin
        capture_d = cap_rise ? count_q : capture_q;
        capf_d    = capf_q;
        if (wr_status && csr_di[1]) begin
            capf_d = 1'b0;
        end
        if (cap_rise) begin
            capf_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cap_sync_q <= 2'b00;
            cap_prev_q <= 1'b0;
            capture_q  <= 16'h0000;
            capf_q     <= 1'b0;
        end else begin
            cap_sync_q <= {cap_sync_q[0], cap_in};
            cap_prev_q <= cap_sync_q[1];
            capture_q  <= capture_d;
            capf_q     <= capf_d;
        end
    end
`endif

    always_comb begin
        rdata = 16'h0000;
        case (addr)
            AddrCtrl:     rdata = {13'h0000, ctrl_q};
`ifdef TIMER_CAPTURE_EN
            AddrStatus:   rdata = {14'h0000, capf_q, match_q};
            AddrCapture:  rdata = capture_q;
`else
            AddrStatus:   rdata = {15'h0000, match_q};
`endif
            AddrCount:    rdata = count_q;
            AddrCompare:  rdata = compare_q;
            AddrPrescale: rdata = prescale_q;
            default:      rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ctrl_q     <= 3'b000;
            match_q    <= 1'b0;
            count_q    <= 16'h0000;
            compare_q  <= COMPARE_RST;
            prescale_q <= PRESCALE_RST;
            presc_q    <= 16'h0000;
            csr_do_q   <= 16'h0000;
        end else begin
            ctrl_q     <= ctrl_d;
            match_q    <= match_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            presc_q    <= presc_d;
            csr_do_q   <= rdata;
        end
    end

    assign csr_do = csr_do_q;
    assign irq    = match_q & ctrl_q[2];

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: directed scenarios plus randomized auto-reload trials
// checked against an arithmetic model (ticks = elapsed / (PRESCALE+1)).
module tb_csr_timer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic [15:0] csr_a = 16'h0000;
    logic        csr_we = 1'b0;
    logic [15:0] csr_di = 16'h0000;
    logic [15:0] csr_do;
    logic        irq;
`ifdef TIMER_CAPTURE_EN
    logic        cap_in = 1'b0;
`endif

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    csr_timer dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
`ifdef TIMER_CAPTURE_EN
        .cap_in    (cap_in),
`endif
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end just after a falling edge.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        csr_a  = {13'h0000, a};
        csr_di = d;
        csr_we = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        csr_we = 1'b0;
        csr_a  = 16'h0000;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] v);
        csr_a = {13'h0000, a};
        @(posedge sys_clk);
        @(negedge sys_clk);
        v = csr_do;
        csr_a = 16'h0000;
    endtask

    // Auto-reload trial: after k edges from enable, ticks = k/(p+1),
    // COUNT = ticks mod (c+1), MATCH = ticks > c.
    task automatic trial(input int p, input int c, input bit ien, input int w,
                         input string tag);
        int e0;
        int t;
        logic [15:0] v;
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'h0003);
        wr(3'd2, 16'h0000);
        wr(3'd4, 16'(p));
        wr(3'd3, 16'(c));
        wr(3'd0, {13'h0000, ien, 2'b11});
        e0 = cyc;
        repeat (w) begin
            @(negedge sys_clk);
            t = (cyc - e0) / (p + 1);
            check({tag, "_irq"}, {15'h0000, irq}, 16'(ien && (t > c)));
        end
        rd(3'd2, v);
        t = (cyc - 1 - e0) / (p + 1);
        check({tag, "_count"}, v, 16'(t % (c + 1)));
        rd(3'd1, v);
        t = (cyc - 1 - e0) / (p + 1);
        check({tag, "_status"}, v, 16'(t > c));
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] rst_exp [8];
        logic [15:0] wrap_exp [4];
        int e0;

        rst_exp  = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF,
                     16'h0000, 16'h0000, 16'h0000, 16'h0000};
        wrap_exp = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0001};

        #2 sys_rst_n = 1'b0;
        #1;
        check("rst_do_async", csr_do, 16'h0000);
        check("rst_irq_async", {15'h0000, irq}, 16'h0000);
        repeat (3) @(negedge sys_clk);
        check("rst_do_held", csr_do, 16'h0000);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd(3'(i), v);
            check($sformatf("reset_reg%0d", i), v, rst_exp[i]);
        end
        check("reset_irq", {15'h0000, irq}, 16'h0000);

        // Periodic mode: PRESCALE=2, COMPARE=3, IRQEN.
        trial(2, 3, 1'b1, 30, "periodic");
        trial(2, 3, 1'b1, 13, "periodic_first");

        // One-shot: stops at COMPARE with EN cleared.
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'h0003);
        wr(3'd2, 16'h0000);
        wr(3'd4, 16'h0000);
        wr(3'd3, 16'h0005);
        wr(3'd0, 16'h0001);
        repeat (10) begin
            @(negedge sys_clk);
            check("oneshot_irq", {15'h0000, irq}, 16'h0000);
        end
        rd(3'd2, v);
        check("oneshot_count", v, 16'h0005);
        rd(3'd1, v);
        check("oneshot_match", v, 16'h0001);
        rd(3'd0, v);
        check("oneshot_ctrl", v, 16'h0000);

        // Wrap from 16'hFFFF through 0 to COMPARE=1.
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'h0003);
        wr(3'd4, 16'h0000);
        wr(3'd3, 16'h0001);
        wr(3'd2, 16'hFFFF);
        wr(3'd0, 16'h0001);
        csr_a = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check($sformatf("wrap_step%0d", i), csr_do, wrap_exp[i]);
        end
        csr_a = 16'h0000;
        rd(3'd1, v);
        check("wrap_match", v, 16'h0001);

        // Clear coinciding with a match: set wins.
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'h0003);
        wr(3'd2, 16'h0000);
        wr(3'd4, 16'h0000);
        wr(3'd3, 16'h0002);
        wr(3'd0, 16'h0007);
        repeat (2) @(negedge sys_clk);
        wr(3'd1, 16'h0001);
        check("setwins_irq", {15'h0000, irq}, 16'h0001);
        rd(3'd1, v);
        check("setwins_match", v, 16'h0001);
        wr(3'd0, 16'h0004);
        check("clear_irq_before", {15'h0000, irq}, 16'h0001);
        wr(3'd1, 16'h0001);
        check("clear_irq_after", {15'h0000, irq}, 16'h0000);
        rd(3'd1, v);
        check("clear_match", v, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            trial(int'($urandom_range(3, 0)), int'($urandom_range(7, 0)),
                  1'($urandom_range(1, 0)), int'($urandom_range(40, 5)),
                  $sformatf("rand%0d", i));
        end

`ifdef TIMER_CAPTURE_EN
        // Edge reaches the detector two edges after cap_in rises, capturing 16'h0042.
        wr(3'd0, 16'h0000);
        wr(3'd1, 16'h0003);
        wr(3'd4, 16'h0000);
        wr(3'd3, 16'hFFFF);
        wr(3'd2, 16'h0040);
        wr(3'd0, 16'h0003);
        cap_in = 1'b1;
        repeat (3) @(negedge sys_clk);
        cap_in = 1'b0;
        rd(3'd5, v);
        check("capture_value", v, 16'h0042);
        rd(3'd1, v);
        check("capture_capf", v, 16'h0002);
`endif

        // Reset asserted mid-count.
        wr(3'd0, 16'h0000);
        wr(3'd4, 16'h0000);
        wr(3'd3, 16'hFFFF);
        wr(3'd2, 16'h0010);
        wr(3'd0, 16'h0007);
        csr_a = 16'h0002;
        repeat (4) @(negedge sys_clk);
        e0 = cyc;
        check("midrst_pre", csr_do, 16'h0013);
        #2 sys_rst_n = 1'b0;
        #1;
        check("midrst_do_async", csr_do, 16'h0000);
        check("midrst_irq_async", {15'h0000, irq}, 16'h0000);
        @(negedge sys_clk);
        csr_a = 16'h0000;
        sys_rst_n = 1'b1;
        rd(3'd2, v);
        check("midrst_count", v, 16'h0000);
        rd(3'd0, v);
        check("midrst_ctrl", v, 16'h0000);
        rd(3'd3, v);
        check("midrst_compare", v, 16'hFFFF);
        repeat (3) @(negedge sys_clk);
        rd(3'd2, v);
        check("midrst_count_idle", v, 16'h0000);
        if (e0 < 0) $display("unexpected cycle counter");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
